// File: rtl/gameplay_fsm_pkg.sv
// Shared definitions for the gameplay controller: legacy-compatible state codes
// and the width helpers also used by the display/score blocks.
package gameplay_fsm_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] PLAYING     = 3'd0;
    localparam logic [STATE_W-1:0] YOU_WIN     = 3'd1;
    localparam logic [STATE_W-1:0] GAME_OVER   = 3'd2;
    localparam logic [STATE_W-1:0] RESPAWN     = 3'd3;
    localparam logic [STATE_W-1:0] LEVEL_CLEAR = 3'd4;

    function automatic int lives_width(input int n_lives);
        return $clog2(n_lives + 1);
    endfunction

    function automatic int level_width(input int n_levels);
        return (n_levels <= 1) ? 1 : $clog2(n_levels);
    endfunction

    // Must hold both PAUSE_CYCLES-1 and the post-reload guard value of 2.
    function automatic int timer_width(input int pause_cycles);
        return (pause_cycles <= 2) ? 2 : $clog2(pause_cycles);
    endfunction

endpackage

// File: rtl/gameplay_timer.sv
// Loadable down-counter shared by the respawn pause, level-clear pause and
// the post-reload guard; sticks at zero.
module gameplay_timer #(
    parameter int W = 2
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/gameplay_fsm.sv
// Game-state controller: lives, levels, respawn and level-clear pauses.
// All outputs are registered.
//
// state       | meaning
// PLAYING     | normal play, motion enabled
// YOU_WIN     | all levels cleared, waits for i_start
// GAME_OVER   | out of lives or invaders landed, waits for i_start
// RESPAWN     | pause after a non-fatal hit
// LEVEL_CLEAR | pause before loading the next level
module gameplay_fsm
    import gameplay_fsm_pkg::*;
#(
    parameter int N_INVADERS     = 20,
    parameter int LINE_W         = 4,
    parameter int GAME_OVER_LINE = 14,
    parameter int N_LIVES        = 3,
    parameter int N_LEVELS       = 4,
    parameter int PAUSE_CYCLES   = 25_000_000
) (
    input  logic                                i_clk_25MHz,
    input  logic                                i_reset,
    input  logic [N_INVADERS-1:0]               i_invaders_array,
    input  logic [LINE_W-1:0]                   i_invaders_line,
    input  logic                                i_player_hit,
    input  logic                                i_start,
    output logic [STATE_W-1:0]                  o_gameplay,
    output logic [lives_width(N_LIVES)-1:0]     o_lives,
    output logic [level_width(N_LEVELS)-1:0]    o_level,
    output logic                                o_freeze,
    output logic                                o_level_advance
);

    localparam int LIVES_W = lives_width(N_LIVES);
    localparam int LEVEL_W = level_width(N_LEVELS);
    localparam int TIMER_W = timer_width(PAUSE_CYCLES);

    localparam logic [LINE_W-1:0]  GO_LINE    = LINE_W'(GAME_OVER_LINE);
    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(N_LIVES);
    localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(N_LEVELS - 1);
    localparam logic [TIMER_W-1:0] PAUSE_LOAD = TIMER_W'(PAUSE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GUARD_LOAD = TIMER_W'(2);

    logic [STATE_W-1:0] state_q, state_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic               freeze_q, freeze_d;
    logic               advance_q, advance_d;

    logic               timer_load;
    logic [TIMER_W-1:0] timer_value;
    logic               timer_dec;
    logic               timer_zero;
    logic               array_empty;

    assign array_empty = (i_invaders_array == '0);

    gameplay_timer #(
        .W (TIMER_W)
    ) u_timer (
        .i_clk   (i_clk_25MHz),
        .i_reset (i_reset),
        .load    (timer_load),
        .value   (timer_value),
        .dec     (timer_dec),
        .zero    (timer_zero)
    );

    always_comb begin
        state_d     = state_q;
        lives_d     = lives_q;
        level_d     = level_q;
        advance_d   = 1'b0;
        timer_load  = 1'b0;
        timer_value = '0;
        timer_dec   = 1'b0;

        case (state_q)
            PLAYING: begin
                if (i_invaders_line >= GO_LINE) begin
                    state_d = GAME_OVER;
                end else if (i_player_hit && (lives_q == LIVES_W'(1))) begin
                    lives_d = '0;
                    state_d = GAME_OVER;
                end else if (i_player_hit) begin
                    lives_d     = lives_q - LIVES_W'(1);
                    state_d     = RESPAWN;
                    timer_load  = 1'b1;
                    timer_value = PAUSE_LOAD;
                end else if (array_empty && timer_zero && (level_q == LAST_LEVEL)) begin
                    state_d = YOU_WIN;
                end else if (array_empty && timer_zero) begin
                    state_d     = LEVEL_CLEAR;
                    timer_load  = 1'b1;
                    timer_value = PAUSE_LOAD;
                end else begin
                    // A running timer here is the guard that hides the stale
                    // empty array until the invader block has reloaded.
                    timer_dec = 1'b1;
                end
            end

            RESPAWN: begin
                if (timer_zero) begin
                    state_d = PLAYING;
                end else begin
                    timer_dec = 1'b1;
                end
            end

            LEVEL_CLEAR: begin
                if (timer_zero) begin
                    level_d     = level_q + LEVEL_W'(1);
                    advance_d   = 1'b1;
                    state_d     = PLAYING;
                    timer_load  = 1'b1;
                    timer_value = GUARD_LOAD;
                end else begin
                    timer_dec = 1'b1;
                end
            end

            YOU_WIN, GAME_OVER: begin
                if (i_start) begin
                    lives_d     = LIVES_INIT;
                    level_d     = '0;
                    advance_d   = 1'b1;
                    state_d     = PLAYING;
                    timer_load  = 1'b1;
                    timer_value = GUARD_LOAD;
                end
            end

            default: begin
                state_d = PLAYING;
            end
        endcase

        freeze_d = (state_d != PLAYING);
    end

    always_ff @(posedge i_clk_25MHz) begin
        if (i_reset) begin
            state_q   <= PLAYING;
            lives_q   <= LIVES_INIT;
            level_q   <= '0;
            freeze_q  <= 1'b0;
            advance_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lives_q   <= lives_d;
            level_q   <= level_d;
            freeze_q  <= freeze_d;
            advance_q <= advance_d;
        end
    end

    assign o_gameplay      = state_q;
    assign o_lives         = lives_q;
    assign o_level         = level_q;
    assign o_freeze        = freeze_q;
    assign o_level_advance = advance_q;

endmodule
